// File: rtl/read_pixel.sv
// read_pixel: fetches one pixel at (x, y) from two parallel BRAMs that share
// the same address map. A request in IDLE registers the raster address, waits
// out the BRAM read latency, captures both data buses and pulses done.
// The addresses stay put after capture so the BRAMs keep presenting the
// same pixel until the next accepted request.
module read_pixel #(
    parameter int DIMENSION   = 4,
    parameter int BIT_DEPTH   = 9,
    parameter int RAM_LATENCY = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_in,
    input  logic                                     input_ready,
    input  logic [$clog2(DIMENSION)-1:0]             x,
    input  logic [$clog2(DIMENSION)-1:0]             y,
    output logic [$clog2(DIMENSION*DIMENSION)-1:0]   first_address,
    input  logic signed [BIT_DEPTH-1:0]              first_data,
    output logic [$clog2(DIMENSION*DIMENSION)-1:0]   second_address,
    input  logic signed [BIT_DEPTH-1:0]              second_data,
    output logic signed [BIT_DEPTH-1:0]              first_pixel_value,
    output logic signed [BIT_DEPTH-1:0]              second_pixel_value,
    output logic                                     busy,
    output logic                                     done
);

    localparam int AW    = $clog2(DIMENSION*DIMENSION);
    // The wait counter runs 0 .. RAM_LATENCY-1; keep at least one bit.
    localparam int CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    // Terminal count; a latency of 0 is treated like 1 (one wait edge).
    localparam logic [CNT_W-1:0] CNT_LAST =
        (RAM_LATENCY > 1) ? CNT_W'(RAM_LATENCY - 1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t                       r_state;
    logic [CNT_W-1:0]             r_count;
    logic [AW-1:0]                r_first_address;
    logic [AW-1:0]                r_second_address;
    logic signed [BIT_DEPTH-1:0]  r_first_pixel_value;
    logic signed [BIT_DEPTH-1:0]  r_second_pixel_value;
    logic                         r_busy;
    logic                         r_done;
    logic [AW-1:0]                w_addr;

    // Raster address y*DIMENSION + x, truncated to the address width.
    assign w_addr = AW'(y) * AW'(DIMENSION) + AW'(x);

    // Request FSM: accept in IDLE, count BRAM latency in WAIT, capture data.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            r_state              <= S_IDLE;
            r_count              <= {CNT_W{1'b0}};
            r_first_address      <= {AW{1'b0}};
            r_second_address     <= {AW{1'b0}};
            r_first_pixel_value  <= {BIT_DEPTH{1'b0}};
            r_second_pixel_value <= {BIT_DEPTH{1'b0}};
            r_busy               <= 1'b0;
            r_done               <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (input_ready) begin
                        r_first_address  <= w_addr;
                        r_second_address <= w_addr;
                        r_count          <= {CNT_W{1'b0}};
                        r_busy           <= 1'b1;
                        r_state          <= S_WAIT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    // New requests and x/y changes are ignored while busy.
                    r_done <= 1'b0;
                    if (r_count == CNT_LAST) begin
                        r_state <= S_CAPTURE;
                    end else begin
                        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_CAPTURE: begin
                    r_first_pixel_value  <= first_data;
                    r_second_pixel_value <= second_data;
                    r_done               <= 1'b1;
                    r_busy               <= 1'b0;
                    r_state              <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign first_address      = r_first_address;
    assign second_address     = r_second_address;
    assign first_pixel_value  = r_first_pixel_value;
    assign second_pixel_value = r_second_pixel_value;
    assign busy               = r_busy;
    assign done               = r_done;

endmodule

// File: tb/tb_read_pixel.sv
// Bench for read_pixel: two latency-2 BRAM models (first[a]=a-8,
// second[a]=100-a), directed requests, expected results queued per request
// and checked when done pulses.
module tb_read_pixel;

    localparam int DIM = 4;
    localparam int BD  = 9;
    localparam int AW  = $clog2(DIM*DIM);
    localparam int CW  = $clog2(DIM);

    logic                  clk;
    logic                  rst_in;
    logic                  input_ready;
    logic [CW-1:0]         x;
    logic [CW-1:0]         y;
    logic [AW-1:0]         first_address;
    logic [AW-1:0]         second_address;
    logic signed [BD-1:0]  first_data;
    logic signed [BD-1:0]  second_data;
    logic signed [BD-1:0]  first_pixel_value;
    logic signed [BD-1:0]  second_pixel_value;
    logic                  busy;
    logic                  done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int addr;
        int f;
        int s;
    } exp_t;
    exp_t q[$];

    read_pixel #(.DIMENSION(DIM), .BIT_DEPTH(BD), .RAM_LATENCY(2)) dut (
        .clk                (clk),
        .rst_in             (rst_in),
        .input_ready        (input_ready),
        .x                  (x),
        .y                  (y),
        .first_address      (first_address),
        .first_data         (first_data),
        .second_address     (second_address),
        .second_data        (second_data),
        .first_pixel_value  (first_pixel_value),
        .second_pixel_value (second_pixel_value),
        .busy               (busy),
        .done               (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models: address register then output register (latency 2).
    logic [AW-1:0] ram_a1;
    logic [AW-1:0] ram_a2;
    always @(posedge clk) begin
        ram_a1      <= first_address;
        ram_a2      <= second_address;
        first_data  <= BD'(int'(ram_a1) - 8);
        second_data <= BD'(100 - int'(ram_a2));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Drive a one-cycle request; returns #1 after the accepting edge E0.
    task automatic request(input int rx, input int ry);
        exp_t e;
        @(negedge clk);
        x           = CW'(rx);
        y           = CW'(ry);
        input_ready = 1'b1;
        e.addr = (ry * DIM + rx) % (DIM * DIM);
        e.f    = e.addr - 8;
        e.s    = 100 - e.addr;
        q.push_back(e);
        @(posedge clk);
        #1;
        input_ready = 1'b0;
    endtask

    // Wait (bounded) for done, check latency in negedges, pop and compare.
    task automatic wait_done(input int exp_lat);
        int   lat;
        exp_t e;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("done_latency", 32'(lat), 32'(exp_lat));
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("first_pixel",  32'(first_pixel_value),  32'(e.f));
            chk("second_pixel", 32'(second_pixel_value), 32'(e.s));
            chk("first_addr",   32'(first_address),      32'(e.addr));
            chk("second_addr",  32'(second_address),     32'(e.addr));
            chk("busy_at_done", 32'(busy),               32'd0);
        end else begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end
    endtask

    task automatic pulse_end();
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int dcount;
        rst_in      = 1'b0;
        input_ready = 1'b0;
        x           = '0;
        y           = '0;
        #2;
        // Reset state (asynchronous, before any clock edge)
        chk("rst_busy",   32'(busy),               32'd0);
        chk("rst_done",   32'(done),               32'd0);
        chk("rst_addr1",  32'(first_address),      32'd0);
        chk("rst_addr2",  32'(second_address),     32'd0);
        chk("rst_pix1",   32'(first_pixel_value),  32'd0);
        chk("rst_pix2",   32'(second_pixel_value), 32'd0);
        repeat (2) @(negedge clk);
        rst_in = 1'b1;

        // Basic read at (0,0); busy asserted right after accept
        request(0, 0);
        chk("busy_after_accept", 32'(busy), 32'd1);
        wait_done(4);
        pulse_end();

        // Corner (3,3)
        request(3, 3);
        wait_done(4);
        pulse_end();

        // Raster sweep over the whole image
        for (int yy = 0; yy < DIM; yy++) begin
            for (int xx = 0; xx < DIM; xx++) begin
                request(xx, yy);
                wait_done(4);
                pulse_end();
            end
        end

        // Address stays stable after capture
        repeat (3) @(negedge clk);
        chk("addr_hold", 32'(first_address), 32'd15);

        // Second strobe at E1 with different x is ignored
        request(0, 0);
        x           = CW'(1);
        input_ready = 1'b1;
        @(posedge clk);
        #1;
        input_ready = 1'b0;
        x           = '0;
        wait_done(3);
        pulse_end();
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("ignored_no_done", 32'(dcount), 32'd0);
        chk("ignored_idle",    32'(busy),   32'd0);

        // Reset at E2 aborts the read
        request(2, 2);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_in = 1'b0;
        void'(q.pop_back());
        #1;
        chk("abort_busy",  32'(busy),               32'd0);
        chk("abort_done",  32'(done),               32'd0);
        chk("abort_addr",  32'(first_address),      32'd0);
        chk("abort_addr2", 32'(second_address),     32'd0);
        chk("abort_pix1",  32'(first_pixel_value),  32'd0);
        chk("abort_pix2",  32'(second_pixel_value), 32'd0);
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        rst_in = 1'b1;
        request(1, 2);
        wait_done(4);
        pulse_end();

        // input_ready held high: done every 4 cycles
        @(negedge clk);
        x           = CW'(2);
        y           = CW'(1);
        input_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.addr = 6;
            e.f    = -2;
            e.s    = 94;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        wait_done(4);
        pulse_end();
        wait_done(3);
        pulse_end();
        wait_done(3);
        input_ready = 1'b0;
        pulse_end();
        repeat (6) @(negedge clk);
        chk("held_stop_idle", 32'(busy), 32'd0);
        chk("queue_drained",  32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
